// File: rtl/nic_link_allocator_if.sv
// Link-allocation bundle between the NIC output buffers/router side (master)
// and nic_link_allocator (slave).
interface nic_link_allocator_if #(
    parameter int N_REQ = 4,
    parameter int N_VC  = 4
);
    localparam int N_BITS_SEL = $clog2(N_REQ);

    logic [N_REQ-1:0]      r_la_i;
    logic [N_REQ*N_VC-1:0] vc_id_i;
    logic [N_VC-1:0]       credit_in_i;
    logic [N_REQ-1:0]      g_la_o;
    logic [N_BITS_SEL-1:0] sel_o;
    logic                  grant_valid_o;
    logic [N_VC-1:0]       credit_avail_o;
    logic                  err_o;

    modport master (
        output r_la_i, vc_id_i, credit_in_i,
        input  g_la_o, sel_o, grant_valid_o, credit_avail_o, err_o
    );
    modport slave (
        input  r_la_i, vc_id_i, credit_in_i,
        output g_la_o, sel_o, grant_valid_o, credit_avail_o, err_o
    );
endinterface

// File: rtl/nic_link_allocator.sv
// Round-robin, credit-aware single-link allocator for the NIC output buffers.
// Optional sticky protocol error: define NIC_LA_ERR_CHECK_EN.

// Per-VC downstream credit counter; saturates at MAX_CREDIT.
module nic_la_credit_cnt #(
    parameter int MAX_CREDIT = 4,
    parameter int W          = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= W'(MAX_CREDIT);
        else if (dec && !inc)
            cnt <= cnt - W'(1);
        else if (inc && !dec && cnt != W'(MAX_CREDIT))
            cnt <= cnt + W'(1);
    end
endmodule

module nic_link_allocator #(
    parameter int N_REQ      = 4,
    parameter int N_VC       = 4,
    parameter int MAX_CREDIT = 4,
    localparam int N_BITS_CREDIT = $clog2(MAX_CREDIT + 1),
    localparam int N_BITS_SEL    = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    nic_link_allocator_if.slave   la
);
    logic [N_REQ-1:0][N_VC-1:0]          vc;
    logic [N_VC-1:0][N_BITS_CREDIT-1:0]  cnt;
    logic [N_VC-1:0]                     cnt_nz, inc, dec;
    logic [N_REQ-1:0]                    onehot, elig, gnt;
    logic [N_BITS_SEL-1:0]               rr_ptr, sel;
    logic                                found;

    assign vc  = la.vc_id_i;
    assign inc = la.credit_in_i;

    genvar k, v;
    generate
        for (k = 0; k < N_REQ; k++) begin : g_req
            assign onehot[k] = (vc[k] != '0) && ((vc[k] & (vc[k] - N_VC'(1))) == '0);
            assign elig[k]   = la.r_la_i[k] && onehot[k] && ((vc[k] & cnt_nz) != '0);
        end
        for (v = 0; v < N_VC; v++) begin : g_vc
            nic_la_credit_cnt #(.MAX_CREDIT(MAX_CREDIT), .W(N_BITS_CREDIT)) u_cnt (
                .clk (clk),
                .rst (rst),
                .inc (inc[v]),
                .dec (dec[v]),
                .cnt (cnt[v])
            );
            assign cnt_nz[v] = (cnt[v] != '0);
        end
    endgenerate

    // First eligible buffer at or after rr_ptr, wrapping.
    always_comb begin
        int idx;
        gnt   = '0;
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && elig[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                sel      = N_BITS_SEL'(idx);
            end
        end
    end

    assign dec = found ? vc[sel] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_ptr <= '0;
        else if (found)
            rr_ptr <= (sel == N_BITS_SEL'(N_REQ - 1)) ? '0 : sel + N_BITS_SEL'(1);
    end

    assign la.g_la_o         = gnt;
    assign la.sel_o          = sel;
    assign la.grant_valid_o  = found;
    assign la.credit_avail_o = cnt_nz;

`ifdef NIC_LA_ERR_CHECK_EN
    logic [N_VC-1:0] ovf;
    logic            err;

    generate
        for (v = 0; v < N_VC; v++) begin : g_ovf
            assign ovf[v] = inc[v] && !dec[v] && (cnt[v] == N_BITS_CREDIT'(MAX_CREDIT));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err <= 1'b0;
        else if ((|ovf) || (|(la.r_la_i & ~onehot)))
            err <= 1'b1;
    end

    assign la.err_o = err;
`else
    assign la.err_o = 1'b0;
`endif
endmodule

// File: tb/tb_nic_link_allocator.sv
// Directed scoreboard bench: each step queues its expected outputs, a negedge
// monitor pops and compares them against the allocator.
module tb_nic_link_allocator;
`ifdef NIC_LA_ERR_CHECK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    typedef struct {
        logic [3:0] g;
        logic [1:0] sel;
        logic [3:0] ca;
        logic       err;
        int         id;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   stepn = 0;
    exp_t expq[$];

    always #5 clk = ~clk;

    nic_link_allocator_if #(.N_REQ(4), .N_VC(4)) la ();

    nic_link_allocator #(.N_REQ(4), .N_VC(4), .MAX_CREDIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .la  (la)
    );

    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            checks++;
            if (la.g_la_o !== e.g || la.sel_o !== e.sel || la.grant_valid_o !== (|e.g) ||
                la.credit_avail_o !== e.ca || la.err_o !== e.err) begin
                failures++;
                $display("FAIL step%0d: got g=%b sel=%0d gv=%b ca=%b err=%b, expected g=%b sel=%0d gv=%b ca=%b err=%b",
                         e.id, la.g_la_o, la.sel_o, la.grant_valid_o, la.credit_avail_o, la.err_o,
                         e.g, e.sel, |e.g, e.ca, e.err);
            end
        end
    end

    task automatic step(input logic r, input logic [3:0] rl, input logic [15:0] vcid,
                        input logic [3:0] cin, input logic [3:0] g, input logic [1:0] s,
                        input logic [3:0] ca, input logic er);
        exp_t e;
        @(posedge clk);
        #1;
        rst            = r;
        la.r_la_i      = rl;
        la.vc_id_i     = vcid;
        la.credit_in_i = cin;
        stepn++;
        e.g = g; e.sel = s; e.ca = ca; e.err = er; e.id = stepn;
        expq.push_back(e);
    endtask

    initial begin
        la.r_la_i      = '0;
        la.vc_id_i     = '0;
        la.credit_in_i = '0;

        // Reset state
        step(1, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 0, 4'hF, 0);

        // Single buffer on VC1 drains its 4 credits
        repeat (4) step(0, 4'b0001, 16'h0002, 4'b0000, 4'b0001, 0, 4'hF, 0);
        step(0, 4'b0001, 16'h0002, 4'b0000, 4'b0000, 0, 4'b1101, 0);

        // All four requesting on distinct VCs, credit returned for the granted VC
        step(1, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 0, 4'hF, 0);
        step(0, 4'b1111, 16'h8421, 4'b0001, 4'b0001, 0, 4'hF, 0);
        step(0, 4'b1111, 16'h8421, 4'b0010, 4'b0010, 1, 4'hF, 0);
        step(0, 4'b1111, 16'h8421, 4'b0100, 4'b0100, 2, 4'hF, 0);
        step(0, 4'b1111, 16'h8421, 4'b1000, 4'b1000, 3, 4'hF, 0);
        step(0, 4'b1111, 16'h8421, 4'b0001, 4'b0001, 0, 4'hF, 0);

        // Drain VC0 via buffer 3 (leaves rr_ptr=0), then zero-credit skip
        step(1, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 0, 4'hF, 0);
        repeat (4) step(0, 4'b1000, 16'h1000, 4'b0000, 4'b1000, 3, 4'hF, 0);
        step(0, 4'b0101, 16'h0401, 4'b0000, 4'b0100, 2, 4'b1110, 0);
        step(0, 4'b0101, 16'h0401, 4'b0001, 4'b0100, 2, 4'b1110, 0);
        step(0, 4'b0101, 16'h0401, 4'b0000, 4'b0001, 0, 4'hF, 0);
        step(0, 4'b0101, 16'h0401, 4'b0000, 4'b0100, 2, 4'b1110, 0);

        // Grant and credit return on VC3 in the same cycle keeps cnt[3]=2
        step(1, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 0, 4'hF, 0);
        repeat (2) step(0, 4'b1000, 16'h8000, 4'b0000, 4'b1000, 3, 4'hF, 0);
        step(0, 4'b1000, 16'h8000, 4'b1000, 4'b1000, 3, 4'hF, 0);
        repeat (2) step(0, 4'b1000, 16'h8000, 4'b0000, 4'b1000, 3, 4'hF, 0);
        step(0, 4'b1000, 16'h8000, 4'b0000, 4'b0000, 0, 4'b0111, 0);
        step(0, 4'b0000, 16'h0000, 4'b1000, 4'b0000, 0, 4'b0111, 0);
        step(0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 0, 4'hF, 0);

        // Credit return at MAX_CREDIT saturates; optional sticky error
        step(1, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 0, 4'hF, 0);
        step(0, 4'b0000, 16'h0000, 4'b0001, 4'b0000, 0, 4'hF, 0);
        step(0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 0, 4'hF, ERR_EN);
        repeat (4) step(0, 4'b0001, 16'h0001, 4'b0000, 4'b0001, 0, 4'hF, ERR_EN);
        step(0, 4'b0001, 16'h0001, 4'b0000, 4'b0000, 0, 4'b1110, ERR_EN);
        // Non-one-hot VC id is never eligible
        step(0, 4'b0010, 16'h0030, 4'b0000, 4'b0000, 0, 4'b1110, ERR_EN);

        // Reset mid-operation with cnt[0]=1 and rr_ptr=1
        step(1, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 0, 4'hF, 0);
        repeat (3) step(0, 4'b0001, 16'h0001, 4'b0000, 4'b0001, 0, 4'hF, 0);
        step(1, 4'b0011, 16'h0021, 4'b0000, 4'b0001, 0, 4'hF, 0);
        step(0, 4'b0011, 16'h0021, 4'b0000, 4'b0001, 0, 4'hF, 0);
        step(0, 4'b0011, 16'h0021, 4'b0000, 4'b0010, 1, 4'hF, 0);

        for (int i = 0; i < 20 && expq.size() > 0; i++) @(posedge clk);
        if (expq.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
